// File: rtl/lcd_pkg.sv
// Shared types and LCD command constants for the LCD bus arbiter.
// Holds the FSM state encoding and the power-up init command table.
package lcd_pkg;

  typedef enum logic [1:0] {
    PWR_WAIT = 2'd0,
    INIT     = 2'd1,
    IDLE     = 2'd2,
    SLOT     = 2'd3
  } state_e;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = FUNC_SET;
      2'd1:    c = ENTRY;
      2'd2:    c = DISP_ON;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD bus signal bundle for the arbiter.
// master = requester/bench side, slave = arbiter side.
interface lcd_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       init_done;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready,
    input  init_done, busy,
    input  lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready,
    output init_done, busy,
    output lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/ms_tick_gen.sv
// One-cycle tick every CNT1MS clocks; clr_i holds the phase at zero
// so a new slot always starts on a fresh millisecond boundary.
module ms_tick_gen #(
  parameter int CNT1MS = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;

  logic [PW-1:0] ph_q, ph_d;

  assign tick_o = (ph_q == PW'(CNT1MS - 1));

  always_comb begin
    ph_d = ph_q + 1'b1;
    if (clr_i || tick_o) ph_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ph_q <= '0;
    else       ph_q <= ph_d;
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter driving a character LCD bus,
// with a built-in power-up wait and four-command init sequence.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int CNT1MS   = 100000,
  parameter int T_PWR_MS = 20,
  parameter int T_CMD_MS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int MSMAX = (T_PWR_MS > T_CMD_MS) ? T_PWR_MS : T_CMD_MS;
  localparam int MSW   = $clog2(MSMAX + 1);

  state_e         state_q, state_d;
  logic [MSW-1:0] ms_q, ms_d;
  logic [1:0]     step_q, step_d;
  logic           rs_q, rs_d;
  logic [7:0]     data_q, data_d;
  logic           last_q, last_d;
  logic           done_q, done_d;

  logic tick, clr, win1, fire;
  logic slot_end, pwr_end, in_slot;

  ms_tick_gen #(
    .CNT1MS (CNT1MS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .tick_o (tick)
  );

  assign clr      = (state_q == IDLE);
  assign slot_end = tick && (ms_q == MSW'(T_CMD_MS - 1));
  assign pwr_end  = tick && (ms_q == MSW'(T_PWR_MS - 1));
  assign in_slot  = (state_q == INIT) || (state_q == SLOT);

  // req1 wins when alone, or when both are valid and req0 went last
  assign win1       = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == IDLE) && req0_valid && !win1;
  assign req1_ready = (state_q == IDLE) && win1;
  assign fire       = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);

  assign init_done = done_q;
  assign busy      = (state_q != IDLE);
  assign lcd_e     = in_slot && (ms_q == MSW'(1));
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = data_q;

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    step_d  = step_q;
    rs_d    = rs_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = done_q;
    if (tick) ms_d = ms_q + 1'b1;
    unique case (state_q)
      PWR_WAIT: begin
        if (pwr_end) begin
          state_d = INIT;
          ms_d    = '0;
          step_d  = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end
      end
      INIT: begin
        if (slot_end) begin
          ms_d = '0;
          if (step_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            data_d = init_cmd(step_q + 2'd1);
          end
        end
      end
      IDLE: begin
        ms_d = '0;
        if (fire) begin
          state_d = SLOT;
          rs_d    = win1 ? req1_rs : req0_rs;
          data_d  = win1 ? req1_data : req0_data;
          last_d  = win1;
        end
      end
      SLOT: begin
        if (slot_end) begin
          state_d = IDLE;
          ms_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      ms_q    <= '0;
      step_q  <= 2'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      step_q  <= step_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 The block SHALL have parameter CNT1MS, default 100000: clk cycles per 1 ms tick.
REQ-002 The block SHALL have parameter T_PWR_MS, default 20: power-up wait in ms before the first LCD command.
REQ-003 The block SHALL have parameter T_CMD_MS, default 4, minimum 3: length of one LCD write slot in ms.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports req0_valid, req1_valid, input, 1 bit each: requester holds a pending LCD write.
REQ-007 The block SHALL have ports req0_rs, req1_rs, input, 1 bit each: 0 = command, 1 = character data.
REQ-008 The block SHALL have ports req0_data, req1_data, input, 8 bits each: byte to write.
REQ-009 The block SHALL have ports req0_ready, req1_ready, output, 1 bit each: accept strobe; handshake completes when valid and ready are both 1 at a clk edge.
REQ-010 The block SHALL have port init_done, output, 1 bit: power-up init sequence is complete.
REQ-011 The block SHALL have port busy, output, 1 bit: a write slot or init step is in progress.
REQ-012 The block SHALL have ports lcd_e (1 bit), lcd_rs (1 bit), lcd_rw (1 bit) and lcd_data (8 bits), all outputs: the LCD bus.

Function
REQ-013 The FSM SHALL have states PWR_WAIT, INIT, IDLE and SLOT; reset SHALL enter PWR_WAIT.
REQ-014 PWR_WAIT SHALL last exactly T_PWR_MS*CNT1MS cycles, then enter INIT.
REQ-015 INIT SHALL issue four slots with rs=0, in order 0x38, 0x06, 0x0C, 0x01, then enter IDLE and set init_done=1.
REQ-016 Every slot (init or requester) SHALL last T_CMD_MS*CNT1MS cycles.
REQ-017 Within a slot, lcd_rs and lcd_data SHALL be held stable for the whole slot.
REQ-018 Within a slot, lcd_e SHALL be 1 only during slot cycles CNT1MS to 2*CNT1MS-1, and 0 otherwise.
REQ-019 Outside a slot, lcd_e SHALL be 0 and lcd_rw SHALL be constant 0 at all times.
REQ-020 reqX_ready SHALL be a combinational decode: 1 only when state==IDLE and X is the current arbitration winner.
REQ-021 reqX_ready SHALL never be 1 before init_done=1.
REQ-022 Arbitration SHALL be round-robin via a last_grant register.
REQ-023 When only one requester is valid, that requester SHALL win.
REQ-024 When both requesters are valid, the requester not equal to last_grant SHALL win.
REQ-025 On handshake, rs/data SHALL be captured, last_grant SHALL be updated, and SLOT SHALL begin on the next cycle.
REQ-026 After a slot ends, the FSM SHALL return to IDLE for at least one cycle, giving a back-to-back period of T_CMD_MS*CNT1MS+1 cycles.
REQ-027 A valid that drops without a handshake SHALL be ignored; no write SHALL be issued for it.
REQ-028 busy SHALL be 1 in PWR_WAIT, INIT and SLOT, and 0 in IDLE.
REQ-029 All internal counters SHALL be wide enough for T_PWR_MS*CNT1MS with no wrap-around.

Reset
REQ-030 When reset=1 at a clk edge, the FSM SHALL go to PWR_WAIT and all counters SHALL clear.
REQ-031 When reset=1 at a clk edge, last_grant SHALL be set to 1 so that req0 wins first.
REQ-032 When reset=1 at a clk edge, outputs SHALL be set to: lcd_e=0, lcd_rs=0, lcd_data=0x00, init_done=0, busy=1, and both ready signals 0.
REQ-033 A reset asserted mid-slot SHALL force lcd_e=0 on the next edge and discard the captured write.
REQ-034 After a reset, the full power-up and init sequence SHALL re-run.

Structure
REQ-035 A shared package lcd_pkg SHALL hold the FSM state enum.
REQ-036 lcd_pkg SHALL hold the LCD command constants FUNC_SET=0x38, ENTRY=0x06, DISP_ON=0x0C, CLEAR=0x01, LINE1=0x80, LINE2=0xC0.
REQ-037 One sub-module, ms_tick_gen (parameter CNT1MS), SHALL produce a one-cycle tick every CNT1MS cycles.
REQ-038 The slot and power-up counters SHALL count ms ticks plus an intra-ms phase counter.

Verification (CNT1MS=10, T_PWR_MS=20, T_CMD_MS=4)
REQ-039 Reset release, no requests -> lcd_e pulses 4 times carrying 0x38/0x06/0x0C/0x01 with rs=0, each 10 cycles wide, starting at cycles 210/250/290/330; init_done rises at cycle 360.
REQ-040 Valid on req0 before init_done -> req0_ready stays 0 until cycle 360, then a single handshake occurs and lcd_data is driven with the req0 byte for 40 cycles.
REQ-041 Both requesters valid continuously (req0 0x41 rs=1, req1 0x80 rs=0) -> slots alternate 0x41, 0x80, 0x41, ... every 41 cycles, starting with req0.
REQ-042 Only req1 valid, 3 writes -> all three granted to req1 back-to-back at a 41-cycle period; last_grant does not block a lone requester.
REQ-043 reset pulsed at slot cycle 15 (lcd_e=1) -> lcd_e=0 the next cycle, init_done=0, and the init sequence restarts from PWR_WAIT with the first lcd_e pulse 210 cycles after release.
REQ-044 req0_valid asserted for 1 cycle during a SLOT, then dropped -> no handshake occurs and no extra lcd_e pulse is produced.
